// File: rtl/shifter_iter_16b.sv
// Iterative shift/rotate unit: moves the operand one bit position per clock,
// with a valid/ready request side and a registered, held result side.

module shifter_iter_16b_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] y_o
);
  logic wrap, right;

  always_comb begin
    wrap  = op_i[1];
    right = op_i[0];
    y_o   = d_i;
    if (right) y_o = {(wrap ? d_i[0] : 1'b0), d_i[WIDTH-1:1]};
    else       y_o = {d_i[WIDTH-2:0], (wrap ? d_i[WIDTH-1] : 1'b0)};
  end
endmodule

module shifter_iter_16b #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_op,
  input  logic [SHAMT_W-1:0] in_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d, step_y;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               accept;

  shifter_iter_16b_step #(.WIDTH(WIDTH)) u_step (
    .d_i  (data_q),
    .op_i (op_q),
    .y_o  (step_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        accept = in_valid;
        if (in_valid) begin
          data_d  = in_data;
          op_d    = in_op;
          cnt_d   = in_shift;
          state_d = (in_shift == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = step_y;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // data_q doubles as the result register; it only changes outside DONE
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = data_q;
  assign busy      = (state_q != S_IDLE);

  logic unused_accept;
  assign unused_accept = accept;
endmodule
